// File: rtl/y86_reg_sequencer_pkg.sv
// Shared definitions for the Y86 register-file sequencer.
//   - icode constants I_HALT..I_POPL
//   - register IDs R_EAX..R_EDI, R_ESP, R_NONE
//   - sequencer FSM state encoding
//   - helpers that fold out-of-range register IDs
package y86_defs;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] R_EAX  = 4'h0;
  localparam logic [3:0] R_ECX  = 4'h1;
  localparam logic [3:0] R_EDX  = 4'h2;
  localparam logic [3:0] R_EBX  = 4'h3;
  localparam logic [3:0] R_ESP  = 4'h4;
  localparam logic [3:0] R_EBP  = 4'h5;
  localparam logic [3:0] R_ESI  = 4'h6;
  localparam logic [3:0] R_EDI  = 4'h7;
  localparam logic [3:0] R_NONE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_EXE  = 3'd3,
    S_WAIT = 3'd4,
    S_WBE  = 3'd5,
    S_WBM  = 3'd6
  } seq_state_t;

  // Only IDs 0-7 address real registers; a bogus source ID reads %eax.
  function automatic logic [2:0] src_sel(input logic [3:0] id);
    return id[3] ? R_EAX[2:0] : id[2:0];
  endfunction

  // A bogus destination ID becomes "no register".
  function automatic logic [3:0] dst_sel(input logic [3:0] id, input logic [3:0] none_id);
    return id[3] ? none_id : id;
  endfunction

endpackage

// File: rtl/y86_reg_sequencer_if.sv
// Bus bundle between the sequencer and its neighbours.
//   fetch/decode : inst_valid, inst_ready, icode, rA, rB
//   register file: srcA, srcB, valA, valB, dstW, Write, wdata
//   execute unit : exe_valid, exe_ready, exe_icode, opA, opB,
//                  res_valid, res_valE, res_valM
//   status       : halted, ins_err
// master = sequencer side, slave = environment side.
interface y86_reg_sequencer_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [2:0]  srcA;
  logic [2:0]  srcB;
  logic [31:0] valA;
  logic [31:0] valB;
  logic [2:0]  dstW;
  logic        Write;
  logic [31:0] wdata;
  logic        exe_valid;
  logic        exe_ready;
  logic [3:0]  exe_icode;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        res_valid;
  logic [31:0] res_valE;
  logic [31:0] res_valM;
  logic        halted;
  logic        ins_err;

  modport master (
    input  inst_valid, icode, rA, rB, valA, valB, exe_ready,
           res_valid, res_valE, res_valM,
    output inst_ready, srcA, srcB, dstW, Write, wdata, exe_valid,
           exe_icode, opA, opB, halted, ins_err
  );

  modport slave (
    output inst_valid, icode, rA, rB, valA, valB, exe_ready,
           res_valid, res_valE, res_valM,
    input  inst_ready, srcA, srcB, dstW, Write, wdata, exe_valid,
           exe_icode, opA, opB, halted, ins_err
  );
endinterface

// File: rtl/y86_reg_sequencer_decode.sv
// Combinational register decode for one Y86 instruction.
//   icode_i, rA_i, rB_i : instruction fields
//   srcA_o, srcB_o      : read selects (bogus IDs fold to register 0)
//   dstE_o, dstM_o      : write IDs (bogus IDs fold to NONE_ID)
module y86_reg_decode
  import y86_defs::*;
#(
  parameter int ESP_ID  = 4,
  parameter int NONE_ID = 15
) (
  input  logic [3:0] icode_i,
  input  logic [3:0] rA_i,
  input  logic [3:0] rB_i,
  output logic [2:0] srcA_o,
  output logic [2:0] srcB_o,
  output logic [3:0] dstE_o,
  output logic [3:0] dstM_o
);

  localparam logic [3:0] ESP  = 4'(ESP_ID);
  localparam logic [3:0] NONE = 4'(NONE_ID);

  logic [3:0] a_id, b_id, e_id, m_id;

  always_comb begin
    a_id = R_EAX;
    b_id = R_EAX;
    e_id = NONE;
    m_id = NONE;
    case (icode_i)
      I_RRMOVL: begin a_id = rA_i; e_id = rB_i; end
      I_IRMOVL: e_id = rB_i;
      I_RMMOVL: begin a_id = rA_i; b_id = rB_i; end
      I_MRMOVL: begin b_id = rB_i; m_id = rA_i; end
      I_OPL:    begin a_id = rA_i; b_id = rB_i; e_id = rB_i; end
      I_CALL:   begin b_id = ESP;  e_id = ESP; end
      I_RET:    begin a_id = ESP;  b_id = ESP;  e_id = ESP; end
      I_PUSHL:  begin a_id = rA_i; b_id = ESP;  e_id = ESP; end
      I_POPL:   begin a_id = ESP;  b_id = ESP;  e_id = ESP; m_id = rA_i; end
      default:  ;
    endcase
  end

  assign srcA_o = src_sel(a_id);
  assign srcB_o = src_sel(b_id);
  assign dstE_o = dst_sel(e_id, NONE);
  assign dstM_o = dst_sel(m_id, NONE);

endmodule

// File: rtl/y86_reg_sequencer.sv
// Multi-cycle register-file sequencer for the Simple Y86 core.
// Accepts a decoded instruction, reads its sources, hands operands to the
// execute unit, waits for the result and writes back dstE then dstM.
//   CLK   : clock
//   reset : synchronous, active-high; aborts any instruction in flight
//   bus   : y86_reg_sequencer_if.master (instruction, regfile, execute, status)
//
// state | meaning
// IDLE  | ready for an instruction (unless halted)
// RD    | register file samples srcA/srcB
// CAP   | capture valA/valB into opA/opB
// EXE   | exe_valid held until exe_ready
// WAIT  | waiting for res_valid
// WBE   | write dstE with valE
// WBM   | write dstM with valM, update sticky status
module y86_reg_sequencer
  import y86_defs::*;
#(
  parameter int ESP_ID  = 4,
  parameter int NONE_ID = 15
) (
  input logic CLK,
  input logic reset,
  y86_reg_sequencer_if.master bus
);

  localparam logic [3:0] NONE = 4'(NONE_ID);

  seq_state_t  state_q;
  logic [3:0]  icode_q;
  logic [2:0]  srcA_q, srcB_q;
  logic [3:0]  dstE_q, dstM_q;
  logic [31:0] opA_q, opB_q;
  logic [31:0] valM_q;
  logic        exe_valid_q;
  logic        write_q;
  logic [2:0]  dstW_q;
  logic [31:0] wdata_q;
  logic        halted_q, ins_err_q;

  logic [2:0]  dec_srcA, dec_srcB;
  logic [3:0]  dec_dstE, dec_dstM;

  y86_reg_decode #(.ESP_ID(ESP_ID), .NONE_ID(NONE_ID)) u_decode (
    .icode_i (bus.icode),
    .rA_i    (bus.rA),
    .rB_i    (bus.rB),
    .srcA_o  (dec_srcA),
    .srcB_o  (dec_srcB),
    .dstE_o  (dec_dstE),
    .dstM_o  (dec_dstM)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      icode_q     <= '0;
      srcA_q      <= '0;
      srcB_q      <= '0;
      dstE_q      <= NONE;
      dstM_q      <= NONE;
      opA_q       <= '0;
      opB_q       <= '0;
      valM_q      <= '0;
      exe_valid_q <= 1'b0;
      write_q     <= 1'b0;
      dstW_q      <= '0;
      wdata_q     <= '0;
      halted_q    <= 1'b0;
      ins_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.inst_valid && !halted_q) begin
            icode_q <= bus.icode;
            srcA_q  <= dec_srcA;
            srcB_q  <= dec_srcB;
            dstE_q  <= dec_dstE;
            dstM_q  <= dec_dstM;
            state_q <= S_RD;
          end
        end
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          opA_q       <= bus.valA;
          opB_q       <= bus.valB;
          exe_valid_q <= 1'b1;
          state_q     <= S_EXE;
        end
        S_EXE: begin
          if (bus.exe_ready) begin
            exe_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Write strobe for WBE is staged here so it leaves a flop.
          if (bus.res_valid) begin
            valM_q  <= bus.res_valM;
            write_q <= (dstE_q != NONE);
            dstW_q  <= dstE_q[2:0];
            wdata_q <= bus.res_valE;
            state_q <= S_WBE;
          end
        end
        S_WBE: begin
          // dstM lands after dstE, so popl %esp ends with valM in %esp.
          write_q <= (dstM_q != NONE);
          dstW_q  <= dstM_q[2:0];
          wdata_q <= valM_q;
          state_q <= S_WBM;
        end
        S_WBM: begin
          write_q   <= 1'b0;
          dstW_q    <= '0;
          wdata_q   <= '0;
          halted_q  <= halted_q  | (icode_q == I_HALT);
          ins_err_q <= ins_err_q | (icode_q > I_POPL);
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.inst_ready = (state_q == S_IDLE) && !halted_q;
  assign bus.srcA       = srcA_q;
  assign bus.srcB       = srcB_q;
  assign bus.dstW       = dstW_q;
  assign bus.Write      = write_q;
  assign bus.wdata      = wdata_q;
  assign bus.exe_valid  = exe_valid_q;
  assign bus.exe_icode  = icode_q;
  assign bus.opA        = opA_q;
  assign bus.opB        = opB_q;
  assign bus.halted     = halted_q;
  assign bus.ins_err    = ins_err_q;

endmodule

// File: tb/tb_y86_reg_sequencer.sv
// Bench for y86_reg_sequencer: behavioural register file plus a timeline
// model of every output, checked each cycle, with directed and random
// instructions.
module tb_y86_reg_sequencer;

  localparam int N = 4096;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  y86_reg_sequencer_if bus();

  y86_reg_sequencer #(.ESP_ID(4), .NONE_ID(15)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // Register file: synchronous read (old value on read-during-write), reset clears.
  logic [31:0] rf [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      bus.valA <= '0;
      bus.valB <= '0;
    end else begin
      if (bus.Write) rf[bus.dstW] <= bus.wdata;
      if (pre_we) rf[pre_addr] <= pre_data;
      bus.valA <= rf[bus.srcA];
      bus.valB <= rf[bus.srcB];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int wr_cnt = 0;
  always @(negedge CLK) if (bus.Write === 1'b1) wr_cnt <= wr_cnt + 1;

  // Per-cycle expectations, indexed by the number of the edge opening the cycle.
  bit          exp_ready [N];
  bit          exp_exev  [N];
  bit          exp_we    [N];
  bit          exp_srck  [N];
  bit          exp_halt  [N];
  bit          exp_err   [N];
  logic [2:0]  exp_dst   [N];
  logic [2:0]  exp_sA    [N];
  logic [2:0]  exp_sB    [N];
  logic [31:0] exp_wd    [N];
  logic [31:0] exp_opA   [N];
  logic [31:0] exp_opB   [N];
  logic [3:0]  exp_ic    [N];

  logic [31:0] m_rf [8];
  bit m_halted = 1'b0;
  bit m_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: actual %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic fill_idle(input int from);
    for (int k = from; k < N; k++) begin
      exp_ready[k] = 1'b1; exp_exev[k] = 1'b0; exp_we[k] = 1'b0;
      exp_srck[k] = 1'b0;  exp_halt[k] = 1'b0; exp_err[k] = 1'b0;
    end
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_halted = 1'b0;
    m_err = 1'b0;
  endtask

  // Instruction semantics from the Y86 register usage table.
  function automatic int m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    int id;
    id = 0;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) id = int'(ra);
    else if (ic inside {4'h9, 4'hB}) id = 4;
    return (id < 8) ? id : 0;
  endfunction

  function automatic int m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    int id;
    id = 0;
    if (ic inside {4'h4, 4'h5, 4'h6}) id = int'(rb);
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) id = 4;
    return (id < 8) ? id : 0;
  endfunction

  function automatic int m_dst_e(input logic [3:0] ic, input logic [3:0] rb);
    int id;
    id = 15;
    if (ic inside {4'h2, 4'h3, 4'h6}) id = int'(rb);
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) id = 4;
    return (id < 8) ? id : -1;
  endfunction

  function automatic int m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    int id;
    id = 15;
    if (ic inside {4'h5, 4'hB}) id = int'(ra);
    return (id < 8) ? id : -1;
  endfunction

  always @(negedge CLK) begin
    int c;
    c = cyc;
    if (check_en && c < N) begin
      chk("inst_ready", 32'(bus.inst_ready), 32'(exp_ready[c]));
      chk("exe_valid",  32'(bus.exe_valid),  32'(exp_exev[c]));
      chk("Write",      32'(bus.Write),      32'(exp_we[c]));
      chk("halted",     32'(bus.halted),     32'(exp_halt[c]));
      chk("ins_err",    32'(bus.ins_err),    32'(exp_err[c]));
      if (exp_we[c]) begin
        chk("dstW",  32'(bus.dstW), 32'(exp_dst[c]));
        chk("wdata", bus.wdata,     exp_wd[c]);
      end
      if (exp_exev[c]) begin
        chk("opA",       bus.opA,            exp_opA[c]);
        chk("opB",       bus.opB,            exp_opB[c]);
        chk("exe_icode", 32'(bus.exe_icode), 32'(exp_ic[c]));
      end
      if (exp_srck[c]) begin
        chk("srcA", 32'(bus.srcA), 32'(exp_sA[c]));
        chk("srcB", 32'(bus.srcB), 32'(exp_sB[c]));
      end
    end
  end

  task automatic preload(input int a, input logic [31:0] v);
    pre_we = 1'b1; pre_addr = 3'(a); pre_data = v;
    @(posedge CLK); #1;
    pre_we = 1'b0;
    m_rf[a] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.inst_valid = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b0;
    fill_idle(cyc);
  endtask

  // Entered at #1 after an edge with the sequencer idle. s = extra EXE cycles
  // with exe_ready low, d = extra WAIT cycles before res_valid. abort_j >= 0
  // asserts reset during relative cycle abort_j.
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                           input int s, input int d, input bit ovr,
                           input logic [31:0] ovr_e, input logic [31:0] vm, input int abort_j);
    int A, last, sa, sb, de, dm;
    logic [31:0] oa, ob, ve;
    sa = m_src_a(ic, ra); sb = m_src_b(ic, rb);
    de = m_dst_e(ic, rb); dm = m_dst_m(ic, ra);
    oa = m_rf[sa]; ob = m_rf[sb];
    ve = ovr ? ovr_e : oa + ob;
    last = 6 + s + d;

    bus.inst_valid = 1'b1; bus.icode = ic; bus.rA = ra; bus.rB = rb;
    @(posedge CLK); #1;
    A = cyc;
    if (A + last + 1 >= N) begin
      $display("FAIL cycle_budget: actual %0d, required below %0d", A + last + 1, N);
      $fatal(1, "cycle budget exhausted");
    end

    for (int j = 0; j < last; j++) begin
      exp_ready[A+j] = 1'b0;
      exp_exev[A+j]  = (j >= 2 && j <= 2 + s);
      exp_opA[A+j]   = oa;
      exp_opB[A+j]   = ob;
      exp_ic[A+j]    = ic;
      exp_srck[A+j]  = (j == 0);
      exp_sA[A+j]    = 3'(sa);
      exp_sB[A+j]    = 3'(sb);
      exp_we[A+j]    = 1'b0;
      if (j == 4 + s + d && de >= 0) begin
        exp_we[A+j] = 1'b1; exp_dst[A+j] = 3'(de); exp_wd[A+j] = ve;
      end
      if (j == 5 + s + d && dm >= 0) begin
        exp_we[A+j] = 1'b1; exp_dst[A+j] = 3'(dm); exp_wd[A+j] = vm;
      end
    end
    if (de >= 0) m_rf[de] = ve;
    if (dm >= 0) m_rf[dm] = vm;
    if (ic == 4'h0) m_halted = 1'b1;
    if (ic > 4'hB)  m_err = 1'b1;
    for (int k = A + last; k < N; k++) begin
      exp_ready[k] = !m_halted; exp_halt[k] = m_halted; exp_err[k] = m_err;
    end

    for (int j = 0; j < last; j++) begin
      if (j == abort_j) reset = 1'b1;
      // Offers and handshakes outside their windows must be ignored.
      bus.inst_valid = 1'($urandom);
      bus.icode = 4'($urandom); bus.rA = 4'($urandom); bus.rB = 4'($urandom);
      bus.exe_ready = (j >= 2 && j <= 2 + s) ? (j == 2 + s) : 1'($urandom);
      bus.res_valid = (j >= 3 + s && j <= 3 + s + d) ? (j == 3 + s + d) : 1'($urandom);
      bus.res_valE  = (j == 3 + s + d) ? ve : $urandom;
      bus.res_valM  = (j == 3 + s + d) ? vm : $urandom;
      @(posedge CLK); #1;
      if (j == abort_j) begin
        reset = 1'b0;
        fill_idle(cyc);
        break;
      end
    end
    bus.inst_valid = 1'b0; bus.exe_ready = 1'b0; bus.res_valid = 1'b0;
  endtask

  initial begin
    int w0;
    bus.inst_valid = 1'b0; bus.icode = '0; bus.rA = '0; bus.rB = '0;
    bus.exe_ready = 1'b0; bus.res_valid = 1'b0;
    bus.res_valE = '0; bus.res_valM = '0;
    fill_idle(0);

    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge CLK);
    chk("reset_inst_ready", 32'(bus.inst_ready), 32'd1);
    chk("reset_Write",      32'(bus.Write),      32'd0);
    chk("reset_exe_valid",  32'(bus.exe_valid),  32'd0);
    @(posedge CLK); #1;

    // irmovl $0x100, %edx
    w0 = wr_cnt;
    run_instr(4'h3, 4'hF, 4'h2, 0, 0, 1'b1, 32'h100, 32'hDEADBEEF, -1);
    chk("irmovl_edx", rf[2], 32'h100);
    chk("irmovl_writes", 32'(wr_cnt - w0), 32'd1);

    // addl %ecx, %edx with ecx=5, edx=7
    preload(1, 32'd5);
    preload(2, 32'd7);
    run_instr(4'h6, 4'h1, 4'h2, 0, 0, 1'b0, 32'h0, 32'hDEADBEEF, -1);
    chk("opl_opA", bus.opA, 32'd5);
    chk("opl_opB", bus.opB, 32'd7);
    chk("opl_edx", rf[2], 32'd12);

    // popl %esp: dstE then dstM both hit %esp
    w0 = wr_cnt;
    run_instr(4'hB, 4'h4, 4'hF, 0, 0, 1'b1, 32'h204, 32'h55, -1);
    chk("popl_esp", rf[4], 32'h55);
    chk("popl_writes", 32'(wr_cnt - w0), 32'd2);

    // execute unit stalls 4 cycles, result 2 cycles late
    run_instr(4'h3, 4'hF, 4'h5, 4, 2, 1'b1, 32'h3C, 32'hDEADBEEF, -1);
    chk("stall_ebp", rf[5], 32'h3C);

    // invalid icode, then normal irmovl
    run_instr(4'hC, 4'h1, 4'h2, 0, 0, 1'b0, 32'h0, 32'hDEADBEEF, -1);
    chk("badop_ins_err", 32'(bus.ins_err), 32'd1);
    run_instr(4'h3, 4'hF, 4'h3, 0, 0, 1'b1, 32'h77, 32'hDEADBEEF, -1);
    chk("after_err_ebx", rf[3], 32'h77);

    // random instructions (never halt)
    for (int n = 0; n < 40; n++) begin
      run_instr(4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), $urandom, $urandom, -1);
    end
    for (int i = 0; i < 8; i++) chk("random_rf", rf[i], m_rf[i]);

    // reset while waiting for the result
    w0 = wr_cnt;
    run_instr(4'h3, 4'hF, 4'h2, 0, 3, 1'b1, 32'h999, 32'hDEADBEEF, 4);
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_writes", 32'(wr_cnt - w0), 32'd0);
    chk("abort_inst_ready", 32'(bus.inst_ready), 32'd1);
    for (int i = 0; i < 8; i++) chk("abort_rf_zero", rf[i], 32'd0);

    // halt, then offers are refused until reset
    w0 = wr_cnt;
    run_instr(4'h0, 4'h0, 4'h0, 0, 0, 1'b0, 32'h0, 32'hDEADBEEF, -1);
    bus.inst_valid = 1'b1; bus.icode = 4'h3; bus.rB = 4'h1;
    repeat (5) @(posedge CLK);
    #1;
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_inst_ready", 32'(bus.inst_ready), 32'd0);
    chk("halt_writes", 32'(wr_cnt - w0), 32'd0);
    do_reset();
    @(negedge CLK);
    chk("post_reset_ready", 32'(bus.inst_ready), 32'd1);
    chk("post_reset_halted", 32'(bus.halted), 32'd0);
    @(posedge CLK); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/y86_reg_sequencer.md
Name: y86_reg_sequencer

Overview:
- Drives the read/write side of the 8x32 Y86 register file: accepts one decoded instruction (icode, rA, rB) and selects the source registers.
- Captures the operands the register file returns and hands them to the execute unit through a valid/ready handshake.
- Waits for the result, then writes back up to two destinations (dstE, then dstM).
- Sits between fetch/decode and the register file in the multi-cycle (non-pipelined) Simple core.

Parameters:
- ESP_ID, 4, register ID of %esp.
- NONE_ID, 15, register ID meaning "no register".

Ports:
- CLK  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_valid  in  1  decoded instruction offered
- inst_ready  out  1  sequencer idle; instruction accepted on an edge with valid&ready
- icode  in  4  Y86 icode
- rA  in  4  rA field
- rB  in  4  rB field
- srcA  out  3  register file read port A select
- srcB  out  3  register file read port B select
- valA  in  32  register file read data A
- valB  in  32  register file read data B
- dstW  out  3  register file write select
- Write  out  1  register file write enable
- wdata  out  32  register file write data (drives the register file valE input)
- exe_valid  out  1  operands valid to execute unit
- exe_ready  in  1  execute unit accepts
- exe_icode  out  4  latched icode to execute unit
- opA  out  32  captured valA
- opB  out  32  captured valB
- res_valid  in  1  execute/memory result valid (single-cycle pulse or level)
- res_valE  in  32  ALU result
- res_valM  in  32  memory result
- halted  out  1  sticky; set by halt
- ins_err  out  1  sticky; set by icode > 0xB

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0 except inst_ready=1. Reset mid-operation aborts immediately: no further Write pulses, pending exe/result are dropped, halted and ins_err are cleared.
- FSM states: IDLE -> RD -> CAP -> EXE -> WAIT -> WBE -> WBM -> IDLE. All outputs come from flops or are decoded from the state register only; there is no combinational path from inputs to outputs.
- IDLE: inst_ready=1. On valid&ready with halted=0:
  - latch icode/rA/rB;
  - register srcA/srcB (decode below);
  - compute dstE/dstM;
  - go to RD.
  With halted=1, inst_ready=0 and the sequencer stays in IDLE.
- srcA decode: rA for 2,4,6,A; ESP for 9,B; else 0.
- srcB decode: rB for 4,5,6; ESP for 8,9,A,B; else 0.
- dstE decode: rB for 2,3,6; ESP for 8,9,A,B; else NONE.
- dstM decode: rA for 5,B; else NONE.
- Register field handling: only IDs 0-7 are valid. An ID >= 8 used as a source reads register 0; an ID >= 8 used as a destination is treated as NONE.
- RD: one wait cycle. The register file samples srcA/srcB at the closing edge.
- CAP: latch opA<=valA, opB<=valB and set exe_valid=1; go to EXE.
- EXE: hold exe_valid, opA, opB and exe_icode stable until the edge where exe_ready=1. Then deassert exe_valid and go to WAIT.
- WAIT: on an edge with res_valid=1, latch valE/valM and go to WBE.
- WBE: Write=1, dstW=dstE, wdata=valE if dstE != NONE; otherwise Write=0.
- WBM: Write=1, dstW=dstM, wdata=valM if dstM != NONE; otherwise Write=0. Go to IDLE.
- Write ordering: dstM is written after dstE, so for popl %esp the final %esp is valM (Y86 semantics).
- Halt and invalid icode:
  - icode 0 (halt): no writes; sets halted when leaving WBM.
  - icode > 0xB: no writes; sets ins_err when leaving WBM. The sequencer keeps accepting instructions.
- Latency: with exe_ready and res_valid both high, the instruction is accepted at edge 0 and inst_ready is high again 7 cycles later. WBE is cycle 5 and WBM is cycle 6.
- Register file read-during-write returns the old value. This never arises, because reads and writes are in disjoint states.

Decomposition:
- Shared package y86_defs:
  - icode constants (I_HALT..I_POPL);
  - register IDs (R_EAX..R_EDI, R_ESP, R_NONE);
  - FSM state encoding.
- One natural sub-module, y86_reg_decode: a combinational decode of icode/rA/rB to srcA, srcB, dstE, dstM.

Test Plan:
- Bench structure: the sequencer drives a register file instance; the execute model returns res_valE = opA+opB and res_valM = 0xDEADBEEF.
- irmovl (icode 3, rB=2) with res_valE=0x100 -> a single Write with dstW=2, wdata=0x100 in WBE; no Write in WBM; inst_ready returns 7 cycles after acceptance.
- opl (icode 6, rA=1, rB=2), with ecx=5 and edx=7 -> opA=5, opB=7, edx=12 after WBE.
- popl %esp (icode B, rA=4), with valE=0x204 and valM=0x55 -> WBE writes esp=0x204, then WBM writes esp=0x55; final esp=0x55.
- exe_ready held low for 4 cycles -> exe_valid, opA and opB stay stable for those 4 cycles; no Write until after res_valid.
- reset asserted in WAIT -> next cycle state is IDLE with inst_ready=1; Write never pulses; register file contents are 0.
- halt (icode 0) -> no Write; halted=1; inst_ready=0 until reset. Icode 0xC -> ins_err=1 and the following irmovl still executes normally.
